// File: rtl/uart_tx_ctrl_if.sv
// Handshake/bus bundle between the TX frame sequencer, its word source and the serializer.
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  par_en;
  logic                  par_typ;
  logic                  ser_done;
  logic                  ser_en;
  logic                  ser_load;
  logic [DATA_WIDTH-1:0] ser_data;
  logic [1:0]            mux_sel;
  logic                  par_bit;
  logic                  busy;
  logic                  frame_err;

  modport master (
    input  data_valid, p_data, par_en, par_typ, ser_done,
    output ser_en, ser_load, ser_data, mux_sel, par_bit, busy, frame_err
  );

  modport slave (
    output data_valid, p_data, par_en, par_typ, ser_done,
    input  ser_en, ser_load, ser_data, mux_sel, par_bit, busy, frame_err
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start / data / parity / stop, one clk per bit time.
// Optional one-entry pending word buffer when UART_TX_PENDING_EN is defined.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned SER_TIMEOUT = DATA_WIDTH + 2
) (
  input logic            clk,
  input logic            rst,
  uart_tx_ctrl_if.master bus
);

  localparam int unsigned TO_W   = $clog2(SER_TIMEOUT + 1);
  localparam int unsigned STOP_W = $clog2(STOP_BITS + 1);

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_DATA  = 2'b01;
  localparam logic [1:0] MUX_PAR   = 2'b10;
  localparam logic [1:0] MUX_STOP  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state, state_n;
  logic [TO_W-1:0]       to_cnt, to_cnt_n;
  logic [STOP_W-1:0]     stop_cnt, stop_cnt_n;
  logic [DATA_WIDTH-1:0] ser_data_q, cap_data;
  logic                  par_en_q, cap_pe, cap_pt, par_n;
  logic                  par_bit_q;
  logic                  ser_load_q, cap;
  logic                  frame_err_q, err_n;
  logic [1:0]            mux_sel_q, mux_sel_n;
  logic                  busy_q, busy_n;
  logic                  ser_en_q, ser_en_n;
  logic                  final_stop, launch_pend;

`ifdef UART_TX_PENDING_EN
  logic                  pend_vld, pend_vld_n, pend_store;
  logic [DATA_WIDTH-1:0] pend_data;
  logic                  pend_pe, pend_pt;
`endif

  // Next state, capture control and next-cycle output decode
  always_comb begin
    state_n     = state;
    to_cnt_n    = to_cnt;
    stop_cnt_n  = stop_cnt;
    cap         = 1'b0;
    err_n       = 1'b0;
    launch_pend = 1'b0;
    cap_data    = bus.p_data;
    cap_pe      = bus.par_en;
    cap_pt      = bus.par_typ;
    mux_sel_n   = MUX_STOP;
    busy_n      = 1'b1;
    ser_en_n    = 1'b0;
    final_stop  = (state == S_STOP) && (stop_cnt == STOP_W'(STOP_BITS - 1));

`ifdef UART_TX_PENDING_EN
    pend_vld_n  = pend_vld;
    pend_store  = 1'b0;
    launch_pend = final_stop && pend_vld;
    // A buffered word always beats a direct request in the final stop cycle
    if (launch_pend) begin
      cap_data   = pend_data;
      cap_pe     = pend_pe;
      cap_pt     = pend_pt;
      pend_vld_n = 1'b0;
    end else if (bus.data_valid && (state != S_IDLE) && !final_stop && !pend_vld) begin
      pend_store = 1'b1;
      pend_vld_n = 1'b1;
    end
`endif

    case (state)
      S_IDLE: begin
        if (bus.data_valid) begin
          cap     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        to_cnt_n = '0;
        state_n  = S_DATA;
      end
      S_DATA: begin
        to_cnt_n = to_cnt + TO_W'(1);
        if (bus.ser_done) begin
          stop_cnt_n = '0;
          state_n    = par_en_q ? S_PARITY : S_STOP;
        end else if (to_cnt == TO_W'(SER_TIMEOUT - 1)) begin
          // Serializer never reported completion: abandon parity, close the frame
          err_n      = 1'b1;
          stop_cnt_n = '0;
          state_n    = S_STOP;
        end
      end
      S_PARITY: begin
        stop_cnt_n = '0;
        state_n    = S_STOP;
      end
      S_STOP: begin
        if (final_stop) begin
          if (launch_pend || bus.data_valid) begin
            cap     = 1'b1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          stop_cnt_n = stop_cnt + STOP_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    case (state_n)
      S_IDLE:   busy_n    = 1'b0;
      S_START:  mux_sel_n = MUX_START;
      S_DATA: begin
        mux_sel_n = MUX_DATA;
        ser_en_n  = 1'b1;
      end
      S_PARITY: mux_sel_n = MUX_PAR;
      S_STOP:   mux_sel_n = MUX_STOP;
      default:  busy_n    = 1'b0;
    endcase

    par_n = (^cap_data) ^ cap_pt;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      to_cnt      <= '0;
      stop_cnt    <= '0;
      ser_data_q  <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      ser_load_q  <= 1'b0;
      frame_err_q <= 1'b0;
      mux_sel_q   <= MUX_STOP;
      busy_q      <= 1'b0;
      ser_en_q    <= 1'b0;
    end else begin
      state       <= state_n;
      to_cnt      <= to_cnt_n;
      stop_cnt    <= stop_cnt_n;
      ser_load_q  <= cap;
      frame_err_q <= err_n;
      mux_sel_q   <= mux_sel_n;
      busy_q      <= busy_n;
      ser_en_q    <= ser_en_n;
      if (cap) begin
        ser_data_q <= cap_data;
        par_en_q   <= cap_pe;
        par_bit_q  <= par_n;
      end
    end
  end

`ifdef UART_TX_PENDING_EN
  // One-entry holding buffer for requests that arrive mid-frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld  <= 1'b0;
      pend_data <= '0;
      pend_pe   <= 1'b0;
      pend_pt   <= 1'b0;
    end else begin
      pend_vld <= pend_vld_n;
      if (pend_store) begin
        pend_data <= bus.p_data;
        pend_pe   <= bus.par_en;
        pend_pt   <= bus.par_typ;
      end
    end
  end
`endif

  assign bus.ser_en    = ser_en_q;
  assign bus.ser_load  = ser_load_q;
  assign bus.ser_data  = ser_data_q;
  assign bus.mux_sel   = mux_sel_q;
  assign bus.par_bit   = par_bit_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: one instance with 1 stop bit, one with 2 stop bits.
module tb_uart_tx_ctrl;

  localparam int unsigned DW = 8;
  // Per-cycle record: {busy, mux_sel[1:0], ser_en, ser_load, frame_err}
  localparam logic [5:0] REC_IDLE  = 6'b0_11_0_0_0;
  localparam logic [5:0] REC_START = 6'b1_00_0_1_0;
  localparam logic [5:0] REC_DATA  = 6'b1_01_1_0_0;
  localparam logic [5:0] REC_PAR   = 6'b1_10_0_0_0;

  logic clk = 1'b0;
  logic rst;
  logic dv, pe, pt, suppress, mon_en;
  logic [DW-1:0] pd;
  int sc1 = 0;
  int sc2 = 0;
  int checks = 0;
  int failures = 0;

  logic [5:0] cq1[$];
  logic [5:0] cq2[$];
  logic [8:0] lq1[$];
  logic [8:0] lq2[$];

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_WIDTH(DW)) b1 ();
  uart_tx_ctrl_if #(.DATA_WIDTH(DW)) b2 ();

  uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

  assign b1.data_valid = dv;
  assign b1.p_data     = pd;
  assign b1.par_en     = pe;
  assign b1.par_typ    = pt;
  assign b2.data_valid = dv;
  assign b2.p_data     = pd;
  assign b2.par_en     = pe;
  assign b2.par_typ    = pt;

  // Serializer model: reports done on the 8th enabled cycle unless suppressed
  always @(posedge clk) sc1 <= b1.ser_en ? sc1 + 1 : 0;
  always @(posedge clk) sc2 <= b2.ser_en ? sc2 + 1 : 0;
  assign b1.ser_done = b1.ser_en && (sc1 == 7) && !suppress;
  assign b2.ser_done = b2.ser_en && (sc2 == 7) && !suppress;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rec(input int id, input logic [5:0] r);
    if (id == 1) cq1.push_back(r);
    else         cq2.push_back(r);
  endtask

  // Expected per-cycle trace and load word for one frame, per selected instance
  task automatic push_frame(input int mask, input logic [7:0] d, input logic p_en,
                            input logic p_ty, input bit tmo);
    for (int id = 1; id <= 2; id++) begin
      if (mask[id-1]) begin
        push_rec(id, REC_START);
        for (int i = 0; i < (tmo ? 10 : 8); i++) push_rec(id, REC_DATA);
        if (p_en && !tmo) push_rec(id, REC_PAR);
        for (int s = 0; s < id; s++) push_rec(id, {1'b1, 2'b11, 1'b0, 1'b0, (tmo && s == 0)});
        if (id == 1) lq1.push_back({d, (^d) ^ p_ty});
        else         lq2.push_back({d, (^d) ^ p_ty});
      end
    end
  endtask

  task automatic mon(input int id, input logic [5:0] obs, input logic [8:0] ld);
    logic [5:0] e;
    logic [8:0] le;
    int sz;
    e = REC_IDLE;
    if (obs[5] === 1'b1) begin
      if (id == 1 && cq1.size() > 0) e = cq1.pop_front();
      if (id == 2 && cq2.size() > 0) e = cq2.pop_front();
    end
    chk($sformatf("cycle_u%0d", id), 32'(obs), 32'(e));
    if (obs[1] === 1'b1) begin
      sz = (id == 1) ? lq1.size() : lq2.size();
      chk($sformatf("load_expected_u%0d", id), 32'(sz > 0), 32'(1));
      if (sz > 0) begin
        le = (id == 1) ? lq1.pop_front() : lq2.pop_front();
        chk($sformatf("ser_word_u%0d", id), 32'(ld), 32'(le));
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(1, {b1.busy, b1.mux_sel, b1.ser_en, b1.ser_load, b1.frame_err}, {b1.ser_data, b1.par_bit});
      mon(2, {b2.busy, b2.mux_sel, b2.ser_en, b2.ser_load, b2.frame_err}, {b2.ser_data, b2.par_bit});
    end
  end

  task automatic send(input int mask, input logic [7:0] d, input logic p_en,
                      input logic p_ty, input bit tmo);
    @(posedge clk); #1;
    dv = 1'b1; pd = d; pe = p_en; pt = p_ty;
    push_frame(mask, d, p_en, p_ty, tmo);
    @(posedge clk); #1;
    // Scramble inputs after capture: the latched values must still apply
    dv = 1'b0; pd = ~d; pe = ~p_en; pt = ~p_ty;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((b1.busy || b2.busy) && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ended"}, 32'(n < 80), 32'(1));
    chk({tag, "_drained"}, 32'(cq1.size() + cq2.size() + lq1.size() + lq2.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; dv = 1'b0; pd = '0; pe = 1'b0; pt = 1'b0;
    suppress = 1'b0; mon_en = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_u1", 32'({b1.busy, b1.mux_sel, b1.ser_en, b1.ser_load, b1.frame_err}), 32'(REC_IDLE));
    chk("rst_u2", 32'({b2.busy, b2.mux_sel, b2.ser_en, b2.ser_load, b2.frame_err}), 32'(REC_IDLE));
    chk("rst_word_u1", 32'({b1.ser_data, b1.par_bit}), 32'(0));
    chk("rst_word_u2", 32'({b2.ser_data, b2.par_bit}), 32'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(posedge clk);

    send(3, 8'hA5, 1'b1, 1'b0, 1'b0);
    wait_idle("a5_even");
    send(3, 8'h01, 1'b1, 1'b1, 1'b0);
    wait_idle("01_odd");
    send(3, 8'h01, 1'b0, 1'b1, 1'b0);
    wait_idle("01_nopar");

    for (int i = 0; i < 3; i++) begin
      logic [7:0] rd;
      rd = 8'($urandom);
      send(3, rd, 1'($urandom), 1'($urandom), 1'b0);
      wait_idle("random");
    end

    // Back-to-back: request held high across the final stop cycle of each instance
    @(posedge clk); #1;
    dv = 1'b1; pd = 8'h3C; pe = 1'b0; pt = 1'b0;
    push_frame(3, 8'h3C, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    pd = 8'hC3;
    push_frame(3, 8'hC3, 1'b0, 1'b0, 1'b0);
`ifdef UART_TX_PENDING_EN
    push_frame(1, 8'hC3, 1'b0, 1'b0, 1'b0);
`endif
    repeat (11) @(posedge clk);
    #1 dv = 1'b0;
    wait_idle("b2b");

    suppress = 1'b1;
    send(3, 8'h77, 1'b1, 1'b0, 1'b1);
    wait_idle("timeout");
    suppress = 1'b0;

    // Abort mid-DATA: line must go high at once
    mon_en = 1'b0;
    @(posedge clk); #1;
    dv = 1'b1; pd = 8'h55; pe = 1'b1; pt = 1'b0;
    @(posedge clk); #1;
    dv = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_u1", 32'({b1.busy, b1.mux_sel, b1.ser_en, b1.ser_load, b1.frame_err}), 32'(REC_IDLE));
    chk("abort_u2", 32'({b2.busy, b2.mux_sel, b2.ser_en, b2.ser_load, b2.frame_err}), 32'(REC_IDLE));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    send(3, 8'h81, 1'b1, 1'b1, 1'b0);
    wait_idle("post_abort");

`ifdef UART_TX_PENDING_EN
    send(3, 8'h5A, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 dv = 1'b1; pd = 8'h96; pe = 1'b1; pt = 1'b1;
    push_frame(3, 8'h96, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    pd = 8'hF0; pe = 1'b0; pt = 1'b0;
    @(posedge clk); #1;
    dv = 1'b0;
    wait_idle("pending");
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
